// File: rtl/video_timing_gen_if.sv
// Video stream bundle between the timing generator and the HDMI output path.
// The generator (master) receives the pattern controls and drives the raster
// outputs; a consumer (slave) sees the opposite directions.
interface video_timing_gen_if;
  logic [1:0]  i_pattern_sel;   // 0=bars 1=gradient 2=solid 3=checker
  logic [23:0] i_solid_rgb;     // {r,g,b} used by the solid pattern
  logic [2:0]  o_hve;           // {display_enable, vsync, hsync}
  logic [23:0] o_rgb;           // {r,g,b}
  logic [11:0] o_x;             // column of the pixel on o_rgb
  logic [10:0] o_y;             // line of the pixel on o_rgb
  logic [7:0]  o_frame;         // frame counter, wraps at 256
  logic        o_frame_start;   // high only while output position is (0,0)

  modport master (
    input  i_pattern_sel, i_solid_rgb,
    output o_hve, o_rgb, o_x, o_y, o_frame, o_frame_start
  );

  modport slave (
    output i_pattern_sel, i_solid_rgb,
    input  o_hve, o_rgb, o_x, o_y, o_frame, o_frame_start
  );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing and test-pattern generator feeding the HDMI encoder.
// Stage 0 is the h/v/frame counter plus its combinational decode, stage 1
// registers decode, position and the frame-latched pattern controls, stage 2
// registers the pixel colour and every output, so all outputs for a given
// position leave together two clocks after the counter reaches it.
module video_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic              i_hdmi_clk,
  input  logic              i_reset_n,
  video_timing_gen_if.master vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] H_HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] V_VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  // Left edge of bars 1..7 (entry 0 is the start of bar 1). Comparing against
  // these avoids a divider; anything past the last edge stays in bar 7.
  localparam logic [6:0][11:0] BAR_T = {
    12'(BAR_W * 7), 12'(BAR_W * 6), 12'(BAR_W * 5), 12'(BAR_W * 4),
    12'(BAR_W * 3), 12'(BAR_W * 2), 12'(BAR_W * 1)
  };

  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_GRAD  = 2'd1;
  localparam logic [1:0] PAT_SOLID = 2'd2;
  localparam logic [1:0] PAT_CHECK = 2'd3;

  // ---------------- stage 0: counters and decode ----------------
  logic [11:0] r_h;
  logic [10:0] r_v;
  logic [7:0]  r_frame;
  logic [1:0]  r_pat;
  logic [23:0] r_solid;

  logic        w_h_wrap, w_v_wrap, w_first;
  logic        w_de, w_hs, w_vs;
  logic [1:0]  w_pat;
  logic [23:0] w_solid;

  assign w_h_wrap = (r_h == H_LAST);
  assign w_v_wrap = (r_v == V_LAST);
  assign w_first  = (r_h == 12'd0) && (r_v == 11'd0);

  assign w_de = (r_h < H_ACT) && (r_v < V_ACT);
  assign w_hs = (r_h >= H_HS_BEG) && (r_h < H_HS_END);
  // vsync depends only on v, so it switches together with the line at h=0
  assign w_vs = (r_v >= V_VS_BEG) && (r_v < V_VS_END);

  // The (0,0) pixel already uses the freshly sampled controls; every other
  // position uses the value held since the last frame start.
  assign w_pat   = w_first ? vid.i_pattern_sel : r_pat;
  assign w_solid = w_first ? vid.i_solid_rgb   : r_solid;

  // Raster counters: h every clock, v on h wrap, frame on v wrap
  always_ff @(posedge i_hdmi_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_h     <= '0;
      r_v     <= '0;
      r_frame <= '0;
    end else begin
      if (w_h_wrap) begin
        r_h <= '0;
        if (w_v_wrap) begin
          r_v     <= '0;
          r_frame <= r_frame + 8'd1;
        end else begin
          r_v <= r_v + 11'd1;
        end
      end else begin
        r_h <= r_h + 12'd1;
      end
    end
  end

  // Pattern controls are captured once per frame so a frame never tears
  always_ff @(posedge i_hdmi_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pat   <= PAT_BARS;
      r_solid <= '0;
    end else begin
      r_pat   <= w_pat;
      r_solid <= w_solid;
    end
  end

  // ---------------- stage 1: registered decode and position ----------------
  logic        r1_de, r1_hs, r1_vs, r1_first;
  logic [11:0] r1_x;
  logic [10:0] r1_y;
  logic [7:0]  r1_frame;
  logic [1:0]  r1_pat;
  logic [23:0] r1_solid;

  // Sync outputs are stored at their line level, not as active flags
  always_ff @(posedge i_hdmi_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r1_de    <= 1'b0;
      r1_hs    <= ~HS_POL;
      r1_vs    <= ~VS_POL;
      r1_first <= 1'b0;
      r1_x     <= '0;
      r1_y     <= '0;
      r1_frame <= '0;
      r1_pat   <= PAT_BARS;
      r1_solid <= '0;
    end else begin
      r1_de    <= w_de;
      r1_hs    <= w_hs ? HS_POL : ~HS_POL;
      r1_vs    <= w_vs ? VS_POL : ~VS_POL;
      r1_first <= w_first;
      r1_x     <= r_h;
      r1_y     <= r_v;
      r1_frame <= r_frame;
      r1_pat   <= w_pat;
      r1_solid <= w_solid;
    end
  end

  // ---------------- pixel colour from stage 1 ----------------
  logic [2:0]  w_bar_k;
  logic [23:0] w_bar_rgb;
  logic [23:0] w_pix;
  logic [23:0] w_rgb;

  // Bar index: count how many bar edges the column has passed
  always_comb begin
    w_bar_k = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (r1_x >= BAR_T[i]) w_bar_k = 3'(i + 1);
    end
  end

  // Classic SMPTE-like bar order, white down to black
  always_comb begin
    w_bar_rgb = 24'h000000;
    case (w_bar_k)
      3'd0:    w_bar_rgb = 24'hFFFFFF;
      3'd1:    w_bar_rgb = 24'hFFFF00;
      3'd2:    w_bar_rgb = 24'h00FFFF;
      3'd3:    w_bar_rgb = 24'h00FF00;
      3'd4:    w_bar_rgb = 24'hFF00FF;
      3'd5:    w_bar_rgb = 24'hFF0000;
      3'd6:    w_bar_rgb = 24'h0000FF;
      default: w_bar_rgb = 24'h000000;
    endcase
  end

  // Pattern mux; blanking is forced to black
  always_comb begin
    w_pix = 24'h000000;
    case (r1_pat)
      PAT_BARS:  w_pix = w_bar_rgb;
      PAT_GRAD:  w_pix = {r1_x[7:0], r1_y[7:0], r1_frame};
      PAT_SOLID: w_pix = r1_solid;
      PAT_CHECK: w_pix = {24{r1_x[4] ^ r1_y[4]}};
      default:   w_pix = 24'h000000;
    endcase
    w_rgb = r1_de ? w_pix : 24'h000000;
  end

  // ---------------- stage 2: output registers ----------------
  logic        r2_de, r2_hs, r2_vs, r2_first;
  logic [11:0] r2_x;
  logic [10:0] r2_y;
  logic [7:0]  r2_frame;
  logic [23:0] r2_rgb;

  // Everything for one position is launched on the same edge
  always_ff @(posedge i_hdmi_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r2_de    <= 1'b0;
      r2_hs    <= ~HS_POL;
      r2_vs    <= ~VS_POL;
      r2_first <= 1'b0;
      r2_x     <= '0;
      r2_y     <= '0;
      r2_frame <= '0;
      r2_rgb   <= '0;
    end else begin
      r2_de    <= r1_de;
      r2_hs    <= r1_hs;
      r2_vs    <= r1_vs;
      r2_first <= r1_first;
      r2_x     <= r1_x;
      r2_y     <= r1_y;
      r2_frame <= r1_frame;
      r2_rgb   <= w_rgb;
    end
  end

  assign vid.o_hve         = {r2_de, r2_vs, r2_hs};
  assign vid.o_rgb         = r2_rgb;
  assign vid.o_x           = r2_x;
  assign vid.o_y           = r2_y;
  assign vid.o_frame       = r2_frame;
  assign vid.o_frame_start = r2_first;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: one default 720p instance for line
// timing and bars, one tiny instance (22x7 raster) for patterns, frame timing,
// wrap and async reset, and a tiny negative-polarity instance for sync levels.
module tb_video_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_def, rst_sml, rst_pol;

  video_timing_gen_if if_def ();
  video_timing_gen_if if_sml ();
  video_timing_gen_if if_pol ();

  video_timing_gen u_def (
    .i_hdmi_clk (clk),
    .i_reset_n  (rst_def),
    .vid        (if_def)
  );

  video_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4),  .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_sml (
    .i_hdmi_clk (clk),
    .i_reset_n  (rst_sml),
    .vid        (if_sml)
  );

  video_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4),  .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) u_pol (
    .i_hdmi_clk (clk),
    .i_reset_n  (rst_pol),
    .vid        (if_pol)
  );

  int n_chk = 0;
  int n_err = 0;
  int cur_n = 0;   // output sample index of the small instances; 0 = (0,0)

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to output sample n of the small instances (sampled on negedge)
  task automatic step_to(input int n);
    while (cur_n < n) begin
      @(negedge clk);
      cur_n++;
    end
  endtask

  initial begin
    logic prev_de, prev_hs, de, hs;
    int de_fall, de_rise2, hs_rise, hs_fall;
    logic [23:0] b159, b160, b959, b960, b1280;
    logic [11:0] x1400, x1650;
    logic [10:0] y1400, y1650;

    rst_def = 1'b0; rst_sml = 1'b0; rst_pol = 1'b0;
    if_def.i_pattern_sel = 2'd0; if_def.i_solid_rgb = 24'h0;
    if_sml.i_pattern_sel = 2'd1; if_sml.i_solid_rgb = 24'h0;
    if_pol.i_pattern_sel = 2'd0; if_pol.i_solid_rgb = 24'h0;

    // ---- reset values ----
    repeat (3) @(negedge clk);
    chk("def_rst_hve",   32'(if_def.o_hve),         32'h0);
    chk("def_rst_rgb",   32'(if_def.o_rgb),         32'h0);
    chk("def_rst_x",     32'(if_def.o_x),           32'h0);
    chk("def_rst_y",     32'(if_def.o_y),           32'h0);
    chk("def_rst_frame", 32'(if_def.o_frame),       32'h0);
    chk("def_rst_fs",    32'(if_def.o_frame_start), 32'h0);
    chk("pol_rst_hve",   32'(if_pol.o_hve),         32'h3);

    // ---- default config: first pixel two clocks after release ----
    rst_def = 1'b1;
    @(negedge clk);
    chk("def_lat1_fs",   32'(if_def.o_frame_start), 32'h0);
    @(negedge clk);
    chk("def_first_x",   32'(if_def.o_x),           32'h0);
    chk("def_first_y",   32'(if_def.o_y),           32'h0);
    chk("def_first_hve", 32'(if_def.o_hve),         32'h4);
    chk("def_first_fs",  32'(if_def.o_frame_start), 32'h1);
    chk("def_first_rgb", 32'(if_def.o_rgb),         32'hFFFFFF);

    // ---- default config: one line of edges and bar samples ----
    de_fall = -1; de_rise2 = -1; hs_rise = -1; hs_fall = -1;
    b159 = '0; b160 = '0; b959 = '0; b960 = '0; b1280 = '1;
    x1400 = '0; y1400 = '1; x1650 = '1; y1650 = '0;
    prev_de = if_def.o_hve[2];
    prev_hs = if_def.o_hve[0];
    for (int c = 1; c <= 1660; c++) begin
      @(negedge clk);
      de = if_def.o_hve[2];
      hs = if_def.o_hve[0];
      if (prev_de && !de && de_fall < 0)  de_fall  = c;
      if (!prev_de && de && de_rise2 < 0) de_rise2 = c;
      if (!prev_hs && hs && hs_rise < 0)  hs_rise  = c;
      if (prev_hs && !hs && hs_fall < 0)  hs_fall  = c;
      case (c)
        159:  b159  = if_def.o_rgb;
        160:  b160  = if_def.o_rgb;
        959:  b959  = if_def.o_rgb;
        960:  b960  = if_def.o_rgb;
        1280: b1280 = if_def.o_rgb;
        1400: begin x1400 = if_def.o_x; y1400 = if_def.o_y; end
        1650: begin x1650 = if_def.o_x; y1650 = if_def.o_y; end
        default: ;
      endcase
      prev_de = de;
      prev_hs = hs;
    end
    chk("def_de_fall",  32'(de_fall),  32'd1280);
    chk("def_hs_rise",  32'(hs_rise),  32'd1390);
    chk("def_hs_fall",  32'(hs_fall),  32'd1430);
    chk("def_de_rise2", 32'(de_rise2), 32'd1650);
    chk("def_bar159",   32'(b159),     32'hFFFFFF);
    chk("def_bar160",   32'(b160),     32'hFFFF00);
    chk("def_bar959",   32'(b959),     32'hFF0000);
    chk("def_bar960",   32'(b960),     32'h0000FF);
    chk("def_blank_rgb",32'(b1280),    32'h0);
    chk("def_x1400",    32'(x1400),    32'd1400);
    chk("def_y1400",    32'(y1400),    32'd0);
    chk("def_x1650",    32'(x1650),    32'd0);
    chk("def_y1650",    32'(y1650),    32'd1);

    // ---- small configs: release together, gradient latched at (0,0) ----
    chk("sml_rst_hve", 32'(if_sml.o_hve), 32'h0);
    chk("pol_rst_hve2",32'(if_pol.o_hve), 32'h3);
    rst_sml = 1'b1; rst_pol = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cur_n = 0;
    chk("sml_n0_x",   32'(if_sml.o_x),           32'd0);
    chk("sml_n0_y",   32'(if_sml.o_y),           32'd0);
    chk("sml_n0_fs",  32'(if_sml.o_frame_start), 32'h1);
    chk("sml_n0_hve", 32'(if_sml.o_hve),         32'h4);
    chk("pol_n0_hve", 32'(if_pol.o_hve),         32'h7);
    step_to(1);
    chk("sml_n1_fs",  32'(if_sml.o_frame_start), 32'h0);
    chk("sml_grad_x1",32'(if_sml.o_rgb),         32'h010000);
    step_to(5);
    chk("sml_grad_x5",32'(if_sml.o_rgb),         32'h050000);
    step_to(16);
    chk("sml_hblank_rgb", 32'(if_sml.o_rgb), 32'h0);
    chk("sml_hblank_hve", 32'(if_sml.o_hve), 32'h0);
    step_to(18);
    chk("sml_hs_on",  32'(if_sml.o_hve), 32'h1);
    chk("sml_x18",    32'(if_sml.o_x),   32'd18);
    chk("pol_hs_on",  32'(if_pol.o_hve), 32'h2);
    step_to(20);
    chk("pol_hs_off", 32'(if_pol.o_hve), 32'h3);
    if_sml.i_pattern_sel = 2'd0;              // must not affect frame 0
    step_to(47);
    chk("sml_grad_x3y2", 32'(if_sml.o_rgb), 32'h030200);
    chk("sml_x3",        32'(if_sml.o_x),   32'd3);
    chk("sml_y2",        32'(if_sml.o_y),   32'd2);
    step_to(49);
    chk("sml_grad_held", 32'(if_sml.o_rgb), 32'h050200);
    step_to(110);
    chk("sml_vs_on",  32'(if_sml.o_hve), 32'h2);
    chk("sml_y5",     32'(if_sml.o_y),   32'd5);
    chk("pol_vs_on",  32'(if_pol.o_hve), 32'h1);
    step_to(128);
    chk("sml_vs_hs",  32'(if_sml.o_hve), 32'h3);
    chk("pol_vs_hs",  32'(if_pol.o_hve), 32'h0);
    step_to(132);
    chk("sml_vs_off", 32'(if_sml.o_hve), 32'h0);
    chk("pol_vs_off", 32'(if_pol.o_hve), 32'h3);

    // ---- frame 1: bars ----
    step_to(154);
    chk("f1_fs",    32'(if_sml.o_frame_start), 32'h1);
    chk("f1_frame", 32'(if_sml.o_frame),       32'd1);
    chk("f1_bar_x0",32'(if_sml.o_rgb),         32'hFFFFFF);
    step_to(155);
    chk("f1_bar_x1",32'(if_sml.o_rgb), 32'hFFFFFF);
    step_to(156);
    chk("f1_bar_x2",32'(if_sml.o_rgb), 32'hFFFF00);
    step_to(162);
    chk("f1_bar_x8",32'(if_sml.o_rgb), 32'hFF00FF);
    step_to(167);
    chk("f1_bar_x13",32'(if_sml.o_rgb), 32'h0000FF);
    step_to(169);
    chk("f1_bar_x15",32'(if_sml.o_rgb), 32'h000000);
    step_to(184);
    if_sml.i_pattern_sel = 2'd2;
    if_sml.i_solid_rgb   = 24'h123456;
    step_to(200);
    chk("f1_still_bars", 32'(if_sml.o_rgb), 32'hFFFF00);

    // ---- frame 2: solid ----
    step_to(308);
    chk("f2_frame", 32'(if_sml.o_frame), 32'd2);
    chk("f2_solid0",32'(if_sml.o_rgb),   32'h123456);
    step_to(323);
    chk("f2_solid15",32'(if_sml.o_rgb),  32'h123456);
    step_to(324);
    chk("f2_hblank", 32'(if_sml.o_rgb),  32'h0);
    step_to(338);
    if_sml.i_solid_rgb = 24'hABCDEF;          // must wait for frame 3
    step_to(358);
    chk("f2_solid_held", 32'(if_sml.o_rgb), 32'h123456);
    step_to(396);
    chk("f2_vblank", 32'(if_sml.o_rgb), 32'h0);
    step_to(462);
    chk("f3_frame",  32'(if_sml.o_frame), 32'd3);
    chk("f3_solid",  32'(if_sml.o_rgb),   32'hABCDEF);

    // ---- frame counter wrap ----
    step_to(255 * 154);
    chk("f255_frame", 32'(if_sml.o_frame),       32'd255);
    chk("f255_fs",    32'(if_sml.o_frame_start), 32'h1);
    step_to(256 * 154);
    chk("f256_frame", 32'(if_sml.o_frame),       32'd0);
    chk("f256_fs",    32'(if_sml.o_frame_start), 32'h1);

    // ---- async reset at x=7 of frame 1 after the wrap ----
    step_to(257 * 154 + 7);
    chk("pre_rst_x",     32'(if_sml.o_x),     32'd7);
    chk("pre_rst_frame", 32'(if_sml.o_frame), 32'd1);
    chk("pre_rst_rgb",   32'(if_sml.o_rgb),   32'hABCDEF);
    rst_sml = 1'b0;
    #1;
    chk("arst_x",     32'(if_sml.o_x),           32'd0);
    chk("arst_y",     32'(if_sml.o_y),           32'd0);
    chk("arst_hve",   32'(if_sml.o_hve),         32'h0);
    chk("arst_rgb",   32'(if_sml.o_rgb),         32'h0);
    chk("arst_frame", 32'(if_sml.o_frame),       32'd0);
    chk("arst_fs",    32'(if_sml.o_frame_start), 32'h0);
    @(negedge clk);
    rst_sml = 1'b1;
    @(negedge clk);
    chk("rel_lat1_fs", 32'(if_sml.o_frame_start), 32'h0);
    @(negedge clk);
    chk("rel_fs",    32'(if_sml.o_frame_start), 32'h1);
    chk("rel_x",     32'(if_sml.o_x),           32'd0);
    chk("rel_y",     32'(if_sml.o_y),           32'd0);
    chk("rel_frame", 32'(if_sml.o_frame),       32'd0);
    chk("rel_rgb",   32'(if_sml.o_rgb),         32'hABCDEF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
